// File: rtl/adder_share_pkg.sv
// Shared definitions for the adder_share_arb slice.
//   ADD_W   : datapath width of the shared adder
//   MAX_REQ : upper bound on requesters; sizes rr_pick's search vector
//   occ_e   : pipeline occupancy states
//   rsp_t   : registered result {sum, cout, id}
//   rr_pick : rotating-priority search; returns the first set valid bit at or
//             after ptr (mod n), or -1 when none is set
package adder_share_pkg;

  localparam int unsigned ADD_W   = 32;
  localparam int unsigned MAX_REQ = 16;
  localparam int unsigned MAX_IDW = 4;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  typedef struct packed {
    logic [ADD_W-1:0]   sum;
    logic               cout;
    logic [MAX_IDW-1:0] id;
  } rsp_t;

  function automatic int rr_pick(input logic [MAX_REQ-1:0] valid,
                                 input int unsigned        ptr,
                                 input int unsigned        n);
    int          pick;
    int unsigned j;
    pick = -1;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      j = (ptr + i) % n;
      if (i < n && pick < 0 && ((valid >> j) & MAX_REQ'(1)) != '0)
        pick = int'(j);
    end
    return pick;
  endfunction

endpackage

// File: rtl/adder_share_arb_if.sv
// Request/response bundle for adder_share_arb.
//   req_valid/req_ready : per-requester handshake (NREQ bits)
//   req_a/req_b         : operands, requester i at [32*i +: 32]
//   req_cin             : carry-in per requester
//   rsp_valid/rsp_ready : response handshake
//   rsp_id/rsp_sum/rsp_cout : tagged result
// master = requester side, slave = arbiter side.
interface adder_share_arb_if
  import adder_share_pkg::*;
#(
  parameter int unsigned NREQ = 4
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*ADD_W-1:0] req_a;
  logic [NREQ*ADD_W-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [ADD_W-1:0]      rsp_sum;
  logic                  rsp_cout;

  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

endinterface

// File: rtl/adder_share_arb_rr_arbiter.sv
// Round-robin arbiter: pointer register plus rotate-priority encode.
//   clk, rst : clock, async active-high reset (ptr -> 0)
//   valid    : per-requester request
//   advance  : grant was taken this cycle; ptr moves past the grantee
//   grant    : one-hot grantee (zero when nothing is valid)
//   gid      : index of the grantee
module rr_arbiter
  import adder_share_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] valid,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  gid
);

  logic [IDW-1:0] ptr;
  int             pick;

  always_comb begin
    pick  = rr_pick(MAX_REQ'(valid), 32'(ptr), NREQ);
    grant = '0;
    gid   = '0;
    if (pick >= 0) begin
      gid   = IDW'(pick);
      grant = NREQ'(1) << gid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else if (advance)
      ptr <= (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
  end

endmodule

// File: rtl/brent_kung_32bit.sv
// 32-bit Brent-Kung parallel-prefix adder, purely combinational.
//   a, b : operands      cin  : carry-in
//   sum  : a+b+cin [31:0] cout : carry out of bit 31
module brent_kung_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] hp;
  logic [31:0] g;
  logic [31:0] p;

  // cin is folded into bit 0's generate so every prefix G[i] is the carry
  // out of bit i. Both sweeps update in place: each level only reads
  // positions that level does not write.
  always_comb begin
    hp   = a ^ b;
    g    = a & b;
    p    = hp;
    g[0] = g[0] | (hp[0] & cin);
    for (int unsigned l = 0; l < 5; l++) begin
      for (int unsigned k = 0; k < 32; k++) begin
        if (((k + 1) % (2 << l)) == 0) begin
          g[5'(k)] = g[5'(k)] | (p[5'(k)] & g[5'(k - (1 << l))]);
          p[5'(k)] = p[5'(k)] & p[5'(k - (1 << l))];
        end
      end
    end
    for (int unsigned d = 0; d < 4; d++) begin
      for (int unsigned k = 0; k < 32; k++) begin
        if ((k + 1) >= (3 << (3 - d)) &&
            ((k + 1 - (1 << (3 - d))) % (2 << (3 - d))) == 0) begin
          g[5'(k)] = g[5'(k)] | (p[5'(k)] & g[5'(k - (1 << (3 - d)))]);
          p[5'(k)] = p[5'(k)] & p[5'(k - (1 << (3 - d)))];
        end
      end
    end
    sum  = hp ^ {g[30:0], cin};
    cout = g[31];
  end

endmodule

// File: rtl/adder_share_arb.sv
// Shares one brent_kung_32bit adder among NREQ requesters through a
// two-stage pipeline (OP registers -> adder -> RES registers).
//   clk, rst  : clock, async active-high reset
//   bus       : adder_share_arb_if.slave (requests in, tagged responses out)
//   busy      : either pipeline stage holds data
// Optional (macro ADDER_SHARE_ARB_STATS_EN):
//   stats_clr : synchronous clear of all grant counters
//   grant_cnt : saturating accept counters, requester i at [CNTW*i +: CNTW]
module adder_share_arb
  import adder_share_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
`ifdef ADDER_SHARE_ARB_STATS_EN
  parameter  int unsigned CNTW = 16,
`endif
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  adder_share_arb_if.slave      bus,
`ifdef ADDER_SHARE_ARB_STATS_EN
  input  logic                  stats_clr,
  output logic [NREQ*CNTW-1:0]  grant_cnt,
`endif
  output logic                  busy
);

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   gid;
  logic             accept, drain, res_free, op_free;
  logic             op_v, res_v;
  logic [ADD_W-1:0] op_a, op_b, add_sum;
  logic             op_cin, add_cout;
  logic [IDW-1:0]   op_id;
  rsp_t             rsp_q;
  occ_e             occ, occ_n;

  assign res_free = !res_v | bus.rsp_ready;
  assign op_free  = !op_v | res_free;
  // Gated by rst so req_ready reads zero while reset is held.
  assign bus.req_ready = (op_free && !rst) ? grant : '0;
  assign accept   = |(bus.req_valid & bus.req_ready);
  assign drain    = res_v & bus.rsp_ready;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (bus.req_valid),
    .advance (accept),
    .grant   (grant),
    .gid     (gid)
  );

  brent_kung_32bit u_add (
    .a    (op_a),
    .b    (op_b),
    .cin  (op_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_v   <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      op_cin <= 1'b0;
      op_id  <= '0;
    end else if (accept) begin
      op_v   <= 1'b1;
      op_a   <= bus.req_a[ADD_W*gid +: ADD_W];
      op_b   <= bus.req_b[ADD_W*gid +: ADD_W];
      op_cin <= bus.req_cin[gid];
      op_id  <= gid;
    end else if (res_free) begin
      op_v   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_v <= 1'b0;
      rsp_q <= '0;
    end else if (res_free) begin
      res_v <= op_v;
      if (op_v) begin
        rsp_q.sum  <= add_sum;
        rsp_q.cout <= add_cout;
        rsp_q.id   <= MAX_IDW'(op_id);
      end
    end
  end

  assign bus.rsp_valid = res_v;
  assign bus.rsp_sum   = rsp_q.sum;
  assign bus.rsp_cout  = rsp_q.cout;
  assign bus.rsp_id    = IDW'(rsp_q.id);

  // Occupancy counts operations in flight; internal OP->RES moves do not
  // change it, so busy tracks op_v | res_v exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      occ <= OCC_EMPTY;
    else
      occ <= occ_n;
  end

  always_comb begin
    occ_n = occ;
    case (occ)
      OCC_EMPTY: if (accept) occ_n = OCC_ONE;
      OCC_ONE: begin
        if (accept && !drain)      occ_n = OCC_FULL;
        else if (!accept && drain) occ_n = OCC_EMPTY;
      end
      OCC_FULL:  if (drain && !accept) occ_n = OCC_ONE;
      default:   occ_n = OCC_EMPTY;
    endcase
  end

  assign busy = (occ != OCC_EMPTY);

`ifdef ADDER_SHARE_ARB_STATS_EN
  logic [CNTW-1:0] cnt [NREQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else if (stats_clr) begin
      for (int unsigned i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else if (accept) begin
      for (int unsigned i = 0; i < NREQ; i++)
        if (grant[i] && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_cnt
    assign grant_cnt[CNTW*i +: CNTW] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_adder_share_arb.sv
module tb_adder_share_arb;
  import adder_share_pkg::*;

  localparam int unsigned NREQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  logic rdy = 1'b1;

  adder_share_arb_if #(.NREQ(NREQ)) bus ();

`ifdef ADDER_SHARE_ARB_STATS_EN
  localparam int unsigned CNTW = 8;
  logic                 stats_clr = 1'b0;
  logic [NREQ*CNTW-1:0] grant_cnt;
  logic [CNTW-1:0]      cnt_m [NREQ];
  adder_share_arb #(.NREQ(NREQ), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .stats_clr(stats_clr),
    .grant_cnt(grant_cnt), .busy(busy));
`else
  adder_share_arb #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy));
`endif

  always #5 clk = ~clk;

  // Requester-side stimulus state.
  logic [NREQ-1:0]    pend = '0;
  logic [NREQ-1:0]    clr_mask = '0;
  logic [NREQ*32-1:0] pa = '0, pb = '0;
  logic [NREQ-1:0]    pc = '0;
  logic [NREQ-1:0]    auto_en = '0;
  int unsigned        prob = 100;
  bit                 rr_mode = 0;

  assign bus.req_valid = pend;
  assign bus.req_a     = pa;
  assign bus.req_b     = pb;
  assign bus.req_cin   = pc;
  assign bus.rsp_ready = rdy;

  typedef struct {
    int          id;
    logic [31:0] sum;
    logic        cout;
    int unsigned edge_no;
  } exp_t;

  exp_t        sb[$];
  int          drained_ids[$];
  bit          log_ids = 0;
  int unsigned mptr = 0;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(4))
      0: return 32'hFFFF_FFFF;
      1: return 32'h0;
      2: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  always @(posedge clk) cyc++;

  // Accepted requests are withdrawn just after the edge that took them, then
  // the random generator may refill idle requesters.
  always @(posedge clk) begin
    #1;
    pend     = pend & ~clr_mask;
    clr_mask = '0;
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (auto_en[i] && !pend[i] && $urandom_range(99) < prob) begin
          pa[32*i +: 32] = rand_word();
          pb[32*i +: 32] = rand_word();
          pc[i]          = 1'($urandom_range(1));
          pend[i]        = 1'b1;
        end
      end
      if (rr_mode) rdy = ($urandom_range(99) < 70);
    end
  end

  // Reference model + monitor: decides, from the requesters' view, who must be
  // granted at the coming edge and what the response port must show now.
  always @(negedge clk) begin
    int          g;
    int unsigned j;
    logic [NREQ-1:0] exp_rdy;
    bit          acc, exp_rv;
    logic [32:0] full;
    exp_t        e;
    if (!rst) begin
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        j = (mptr + k) % NREQ;
        if (g < 0 && pend[j]) g = int'(j);
      end
      acc = (g >= 0) && (sb.size() < 2 || rdy);
      exp_rdy = '0;
      if (acc) exp_rdy[g] = 1'b1;
      check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      exp_rv = (sb.size() > 0) && (sb[0].edge_no < cyc);
      check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
      check("busy", 64'(busy), 64'(sb.size() > 0));
      if (exp_rv) begin
        check("rsp_id", 64'(bus.rsp_id), 64'(sb[0].id));
        check("rsp_sum", 64'(bus.rsp_sum), 64'(sb[0].sum));
        check("rsp_cout", 64'(bus.rsp_cout), 64'(sb[0].cout));
      end
`ifdef ADDER_SHARE_ARB_STATS_EN
      for (int i = 0; i < NREQ; i++)
        check("grant_cnt", 64'(grant_cnt[CNTW*i +: CNTW]), 64'(cnt_m[i]));
      if (stats_clr) begin
        for (int i = 0; i < NREQ; i++) cnt_m[i] = '0;
      end else if (acc && cnt_m[g] != '1) begin
        cnt_m[g] = cnt_m[g] + 1'b1;
      end
`endif
      if (exp_rv && rdy) begin
        if (log_ids) drained_ids.push_back(sb[0].id);
        void'(sb.pop_front());
      end
      if (acc) begin
        full = 33'(pa[32*g +: 32]) + 33'(pb[32*g +: 32]) + 33'(pc[g]);
        e.id = g; e.sum = full[31:0]; e.cout = full[32]; e.edge_no = cyc + 1;
        sb.push_back(e);
        mptr = (int'(g) + 1) % NREQ;
        clr_mask[g] = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic issue(input int r, input logic [31:0] a, input logic [31:0] b, input logic c);
    for (int k = 0; k < 50 && pend[r]; k++) tick(1);
    if (pend[r]) check("issue_timeout", 64'(1), 64'(0));
    pa[32*r +: 32] = a;
    pb[32*r +: 32] = b;
    pc[r]          = c;
    pend[r]        = 1'b1;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      if (pend == '0 && sb.size() == 0 && !bus.rsp_valid) done = 1;
      else tick(1);
    end
    if (!done) check("idle_timeout", 64'(0), 64'(1));
  endtask

  // Single isolated request on an idle pipeline with rsp_ready=1.
  task automatic directed(input int r, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic [31:0] esum, input logic ecout);
    issue(r, a, b, c);
    tick(1);
    check("lat_early_valid", 64'(bus.rsp_valid), 64'(0));
    tick(1);
    check("dir_valid", 64'(bus.rsp_valid), 64'(1));
    check("dir_sum", 64'(bus.rsp_sum), 64'(esum));
    check("dir_cout", 64'(bus.rsp_cout), 64'(ecout));
    check("dir_id", 64'(bus.rsp_id), 64'(r));
    wait_idle();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_req_ready"}, 64'(bus.req_ready), 64'(0));
    check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
    check({tag, "_rsp_sum"}, 64'(bus.rsp_sum), 64'(0));
    check({tag, "_rsp_id"}, 64'(bus.rsp_id), 64'(0));
    check({tag, "_rsp_cout"}, 64'(bus.rsp_cout), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  task automatic model_reset();
    auto_en = '0; pend = '0; clr_mask = '0;
    sb.delete(); mptr = 0;
`ifdef ADDER_SHARE_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) cnt_m[i] = '0;
`endif
  endtask

  initial begin
    model_reset();
    // Reset with every requester asking: nothing may be granted or shown.
    #1 rst = 1'b1;
    pend = '1;
    #1 check_quiet("reset");
    pend = '0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    tick(1);
    check("post_reset_busy", 64'(busy), 64'(0));

    directed(2, 32'h0000_0005, 32'h0000_0003, 1'b1, 32'h9, 1'b0);

    // Fairness: all valid continuously.
    drained_ids.delete(); log_ids = 1;
    auto_en = '1; prob = 100; rdy = 1'b1;
    tick(40);
    auto_en = '0;
    wait_idle();
    log_ids = 0;
    check("fair_count", 64'(drained_ids.size() >= 36), 64'(1));
    for (int k = 1; k < drained_ids.size(); k++)
      check("fair_order", 64'(drained_ids[k]), 64'((drained_ids[k-1] + 1) % NREQ));

    // Backpressure with requesters 1 and 3; pointer parked at 1 first.
    directed(0, 32'h1, 32'h2, 1'b0, 32'h3, 1'b0);
    drained_ids.delete(); log_ids = 1;
    rdy = 1'b0;
    issue(1, 32'h1234_5678, 32'h1111_1111, 1'b0);
    issue(3, 32'hDEAD_BEEF, 32'h2222_2222, 1'b1);
    tick(5);
    check("bp_req_ready", 64'(bus.req_ready), 64'(0));
    check("bp_busy", 64'(busy), 64'(1));
    check("bp_rsp_id", 64'(bus.rsp_id), 64'(1));
    check("bp_rsp_sum", 64'(bus.rsp_sum), 64'(32'h2345_6789));
    rdy = 1'b1;
    wait_idle();
    log_ids = 0;
    check("bp_drain_count", 64'(drained_ids.size()), 64'(2));
    if (drained_ids.size() == 2) begin
      check("bp_drain_first", 64'(drained_ids[0]), 64'(1));
      check("bp_drain_second", 64'(drained_ids[1]), 64'(3));
    end

    // Wrap and carry.
    directed(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0, 1'b1);
    directed(3, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 1'b1);

    // Random traffic with random backpressure.
    auto_en = '1; prob = 60; rr_mode = 1;
    tick(400);
    auto_en = '0; rr_mode = 0; rdy = 1'b1;
    wait_idle();

    // Reset mid-operation with the pipeline full and requests pending.
    rdy = 1'b0; auto_en = '1; prob = 100;
    tick(4);
    #2 rst = 1'b1;
    #1 check_quiet("midrst");
    model_reset();
    @(posedge clk);
    #4 rst = 1'b0;
    rdy = 1'b1;
    tick(3);
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    issue(1, 32'h10, 32'h20, 1'b0);
    issue(0, 32'h30, 32'h40, 1'b1);
    wait_idle();

`ifdef ADDER_SHARE_ARB_STATS_EN
    stats_clr = 1'b1; tick(1); stats_clr = 1'b0;
    for (int k = 0; k < 3; k++) directed(0, 32'(k), 32'h5, 1'b0, 32'(k) + 32'h5, 1'b0);
    check("stats_three", 64'(grant_cnt[0 +: CNTW]), 64'(3));
    stats_clr = 1'b1; tick(1); stats_clr = 1'b0;
    tick(1);
    check("stats_clr", 64'(grant_cnt[0 +: CNTW]), 64'(0));
    auto_en = 4'b0001; prob = 100;
    tick(300);
    auto_en = '0;
    wait_idle();
    check("stats_sat", 64'(grant_cnt[0 +: CNTW]), 64'({CNTW{1'b1}}));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
